// File: rtl/morph_ctrl_pkg.sv
// Shared types and helpers for the morphology pipeline frame controller.
package morph_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_BYPASS = 3'd0,
    MODE_ERODE  = 3'd1,
    MODE_DILATE = 3'd2,
    MODE_OPEN   = 3'd3,
    MODE_CLOSE  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    StWaitSync = 2'd0,
    StBlank    = 2'd1,
    StActive   = 2'd2
  } state_e;

  typedef struct packed {
    logic ero_en;
    logic dil_en;
    logic dil_first;
  } stage_en_t;

  function automatic logic mode_valid(input logic [2:0] mode);
    return mode <= 3'd4;
  endfunction

  // Reserved codes decode to all-off; they never reach the active registers anyway.
  function automatic stage_en_t mode_decode(input logic [2:0] mode);
    stage_en_t en;
    en = '0;
    case (mode)
      MODE_ERODE:  en.ero_en = 1'b1;
      MODE_DILATE: en.dil_en = 1'b1;
      MODE_OPEN: begin
        en.ero_en = 1'b1;
        en.dil_en = 1'b1;
      end
      MODE_CLOSE: begin
        en.ero_en    = 1'b1;
        en.dil_en    = 1'b1;
        en.dil_first = 1'b1;
      end
      default: en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/frame_geom_check.sv
// Vsync/DE edge detection plus pixel/line counting; flags frames whose geometry is off.
module frame_geom_check #(
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned IMG_HEIGHT = 720
) (
  input  logic video_clk,
  input  logic rst_n,
  input  logic vs,
  input  logic de,
  input  logic count_en,
  input  logic clear,
  input  logic check,
  output logic vs_rise,
  output logic vs_fall,
  output logic mismatch,
  output logic frame_err
);

  localparam logic [23:0] PixTotal  = 24'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [15:0] LineTotal = 16'(IMG_HEIGHT);

  logic        vs_d_q, de_d_q;
  logic [23:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        frame_err_q;
  logic        de_fall;

  assign vs_rise  = vs & ~vs_d_q;
  assign vs_fall  = ~vs & vs_d_q;
  assign de_fall  = ~de & de_d_q;
  assign mismatch = check & ((pix_cnt_q != PixTotal) | (line_cnt_q != LineTotal));
  assign frame_err = frame_err_q;

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    if (clear) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end else if (count_en) begin
      if (de)      pix_cnt_d  = pix_cnt_q + 24'd1;
      if (de_fall) line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q      <= 1'b0;
      de_d_q      <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      vs_d_q      <= vs;
      de_d_q      <= de;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_err_q <= mismatch;
    end
  end

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame-synchronous config controller: shadows one request and commits it only
// while both pipeline ends are in vertical blanking; also counts and checks frames.
module morph_frame_ctrl
  import morph_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = 1280,
  parameter int unsigned IMG_HEIGHT     = 720,
  parameter logic [7:0]  THRESH_DEFAULT = 8'd128
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic        out_vs,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_mode,
  input  logic [7:0]  cfg_thresh,
  output logic [2:0]  act_mode,
  output logic [7:0]  act_thresh,
  output logic        ero_en,
  output logic        dil_en,
  output logic        dil_first,
  output logic        cfg_pending,
  output logic        cfg_err,
  output logic [15:0] frame_cnt,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam stage_en_t StageEnRst = mode_decode(MODE_OPEN);

  state_e      state_q, state_d;
  logic        vs_rise, vs_fall, mismatch;
  logic        geom_clear, geom_count, geom_check, commit, accept;

  logic [2:0]  shadow_mode_q, shadow_mode_d;
  logic [7:0]  shadow_thresh_q, shadow_thresh_d;
  logic        pending_q, pending_d;
  logic        cfg_err_q, cfg_err_d;
  logic [2:0]  act_mode_q, act_mode_d;
  logic [7:0]  act_thresh_q, act_thresh_d;
  stage_en_t   stage_en_q, stage_en_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  frame_geom_check #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_in_geom (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .vs        (in_vs),
    .de        (in_de),
    .count_en  (geom_count),
    .clear     (geom_clear),
    .check     (geom_check),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .mismatch  (mismatch),
    .frame_err (frame_err)
  );

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state_q <= StWaitSync;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitSync: if (in_vs)   state_d = StBlank;
      StBlank:    if (vs_fall) state_d = StActive;
      StActive:   if (vs_rise) state_d = StBlank;
      default:                 state_d = StWaitSync;
    endcase
  end

  // in_vs must still be high: a falling vsync in the commit cycle defers the request.
  always_comb begin
    geom_clear = (state_q == StBlank) & vs_fall;
    geom_count = (state_q == StActive);
    geom_check = (state_q == StActive) & vs_rise;
    commit     = (state_q == StBlank) & in_vs & out_vs & pending_q;
  end

  assign accept = cfg_valid & ~pending_q;

  always_comb begin
    shadow_mode_d   = shadow_mode_q;
    shadow_thresh_d = shadow_thresh_q;
    pending_d       = pending_q;
    cfg_err_d       = cfg_err_q;
    act_mode_d      = act_mode_q;
    act_thresh_d    = act_thresh_q;
    stage_en_d      = stage_en_q;
    if (accept) begin
      if (mode_valid(cfg_mode)) begin
        shadow_mode_d   = cfg_mode;
        shadow_thresh_d = cfg_thresh;
        pending_d       = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    if (commit) begin
      act_mode_d   = shadow_mode_q;
      act_thresh_d = shadow_thresh_q;
      stage_en_d   = mode_decode(shadow_mode_q);
      pending_d    = 1'b0;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (geom_check)                     frame_cnt_d = frame_cnt_q + 16'd1;
    if (mismatch && err_cnt_q != 8'hFF) err_cnt_d   = err_cnt_q + 8'd1;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mode_q   <= MODE_OPEN;
      shadow_thresh_q <= THRESH_DEFAULT;
      pending_q       <= 1'b0;
      cfg_err_q       <= 1'b0;
      act_mode_q      <= MODE_OPEN;
      act_thresh_q    <= THRESH_DEFAULT;
      stage_en_q      <= StageEnRst;
      frame_cnt_q     <= '0;
      err_cnt_q       <= '0;
    end else begin
      shadow_mode_q   <= shadow_mode_d;
      shadow_thresh_q <= shadow_thresh_d;
      pending_q       <= pending_d;
      cfg_err_q       <= cfg_err_d;
      act_mode_q      <= act_mode_d;
      act_thresh_q    <= act_thresh_d;
      stage_en_q      <= stage_en_d;
      frame_cnt_q     <= frame_cnt_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign cfg_pending = pending_q;
  assign cfg_err     = cfg_err_q;
  assign act_mode    = act_mode_q;
  assign act_thresh  = act_thresh_q;
  assign ero_en      = stage_en_q.ero_en;
  assign dil_en      = stage_en_q.dil_en;
  assign dil_first   = stage_en_q.dil_first;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
